// File: rtl/led_blink_bank.sv
// N-channel LED blinker: each channel runs OFF/ON/BLINK/ONESHOT on its own half-period counter,
// reconfigured one channel per valid/ready transfer. Optional dimming via macro LED_PWM_DIM_EN.
module led_blink_bank #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned DEFAULT_HALF = 10_000_000,
    parameter logic [1:0]  RST_MODE     = 2'b10,
    parameter int unsigned PWM_W        = 4,
    localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             hwclk,
    input  logic             reset_btn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [PWM_W-1:0] cfg_duty,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  wrap
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    mode_e            mode_q [N_CH];
    mode_e            mode_d [N_CH];
    logic [CNT_W-1:0] half_q [N_CH];
    logic [CNT_W-1:0] half_d [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [N_CH-1:0]  on_q;
    logic [N_CH-1:0]  on_d;
    logic [N_CH-1:0]  wrap_q;
    logic [N_CH-1:0]  wrap_d;
    logic [N_CH-1:0]  load_c;
    logic             ready_q;

    // An out-of-range channel index matches no channel, so the transfer is absorbed silently.
    always_comb begin : load_decode
        load_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load_c[i] = cfg_valid && ready_q && (cfg_ch == CH_W'(i));
        end
    end

    // Per-channel next state; a load overrides any terminal event on the same cycle.
    always_comb begin : chan_next
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        on_d   = on_q;
        wrap_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (load_c[i]) begin
                mode_d[i] = mode_e'(cfg_mode);
                half_d[i] = cfg_half;
                cnt_d[i]  = '0;
                on_d[i]   = (cfg_mode != 2'b00);
            end else begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] >= half_q[i]) begin
                            on_d[i]   = ~on_q[i];
                            cnt_d[i]  = '0;
                            wrap_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] >= half_q[i]) begin
                            on_d[i]   = 1'b0;
                            cnt_d[i]  = '0;
                            mode_d[i] = MODE_OFF;
                            wrap_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: cnt_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge hwclk or negedge reset_btn) begin : chan_regs
        if (!reset_btn) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                mode_q[i] <= mode_e'(RST_MODE);
                half_q[i] <= CNT_W'(DEFAULT_HALF);
                cnt_q[i]  <= '0;
            end
            on_q    <= '0;
            wrap_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            wrap_q  <= wrap_d;
            ready_q <= 1'b1;
        end
    end

    assign cfg_ready = ready_q;
    assign wrap      = wrap_q;

`ifdef LED_PWM_DIM_EN
    logic [PWM_W-1:0] pwm_q;
    logic [PWM_W-1:0] pwm_d;
    logic [PWM_W-1:0] duty_q [N_CH];
    logic [PWM_W-1:0] duty_d [N_CH];
    logic [N_CH-1:0]  led_q;
    logic [N_CH-1:0]  led_d;

    // led is computed from next-cycle values so it stays aligned with on/duty/pwm registers.
    always_comb begin : pwm_next
        pwm_d  = pwm_q + PWM_W'(1);
        duty_d = duty_q;
        led_d  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (load_c[i]) begin
                duty_d[i] = cfg_duty;
            end
            led_d[i] = on_d[i] && ((&duty_d[i]) || (pwm_d < duty_d[i]));
        end
    end

    always_ff @(posedge hwclk or negedge reset_btn) begin : pwm_regs
        if (!reset_btn) begin
            pwm_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                duty_q[i] <= '1;
            end
            led_q <= '0;
        end else begin
            pwm_q  <= pwm_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;
`else
    logic unused_duty_c;
    assign unused_duty_c = ^cfg_duty;
    assign led           = on_q;
`endif

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank: directed and random transfers against a closed-form
// per-channel model (LED level and wrap derived from cycles elapsed since the last load or reset).
module tb_led_blink_bank;

    localparam int unsigned N_CH     = 3;
    localparam int unsigned CNT_W    = 26;
    localparam int unsigned PWM_W    = 4;
    localparam int unsigned CH_W     = 2;
    localparam int          DEF_HALF = 3;
    localparam int          DUTY_MAX = (1 << PWM_W) - 1;

    logic             hwclk;
    logic             reset_btn;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_half;
    logic [PWM_W-1:0] cfg_duty;
    logic [N_CH-1:0]  led;
    logic [N_CH-1:0]  wrap;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, half-period, on-level right after load, cycles since load.
    int m_mode [N_CH];
    int m_half [N_CH];
    int m_k    [N_CH];
    bit m_on0  [N_CH];
    int m_duty [N_CH];
    int m_p;

    led_blink_bank #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_HALF(DEF_HALF),
        .RST_MODE    (2'b10),
        .PWM_W       (PWM_W)
    ) dut (
        .hwclk    (hwclk),
        .reset_btn(reset_btn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .cfg_duty (cfg_duty),
        .led      (led),
        .wrap     (wrap)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    function automatic bit chan_on(input int i);
        int per;
        per = m_half[i] + 1;
        case (m_mode[i])
            1:       return 1'b1;
            2:       return m_on0[i] ^ (((m_k[i] / per) % 2) == 1);
            3:       return m_k[i] <= m_half[i];
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_led(input int i);
`ifdef LED_PWM_DIM_EN
        return chan_on(i) && (m_duty[i] == DUTY_MAX || m_p < m_duty[i]);
`else
        return chan_on(i);
`endif
    endfunction

    function automatic bit exp_wrap(input int i);
        int per;
        per = m_half[i] + 1;
        case (m_mode[i])
            2:       return (m_k[i] > 0) && ((m_k[i] % per) == 0);
            3:       return m_k[i] == per;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_mode[i] = 2;
            m_half[i] = DEF_HALF;
            m_k[i]    = 0;
            m_on0[i]  = 1'b0;
            m_duty[i] = DUTY_MAX;
        end
        m_p = 0;
    endtask

    task automatic check(input string tag);
        logic [N_CH-1:0] el;
        logic [N_CH-1:0] ew;
        for (int i = 0; i < N_CH; i++) begin
            el[i] = exp_led(i);
            ew[i] = exp_wrap(i);
        end
        n_tests++;
        assert (led === el) else begin
            n_fail++;
            $error("FAIL %s led observed %b expected %b", tag, led, el);
        end
        n_tests++;
        assert (wrap === ew) else begin
            n_fail++;
            $error("FAIL %s wrap observed %b expected %b", tag, wrap, ew);
        end
        n_tests++;
        assert (cfg_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL %s cfg_ready observed %b expected 1", tag, cfg_ready);
        end
    endtask

    task automatic check_reset(input string tag);
        n_tests++;
        assert (led === '0) else begin
            n_fail++;
            $error("FAIL %s led observed %b expected 000", tag, led);
        end
        n_tests++;
        assert (wrap === '0) else begin
            n_fail++;
            $error("FAIL %s wrap observed %b expected 000", tag, wrap);
        end
        n_tests++;
        assert (cfg_ready === 1'b0) else begin
            n_fail++;
            $error("FAIL %s cfg_ready observed %b expected 0", tag, cfg_ready);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
    task automatic step(input bit v, input int ch, input int mode, input int half,
                        input int duty, input string tag);
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = 2'(mode);
        cfg_half  = CNT_W'(half);
        cfg_duty  = PWM_W'(duty);
        @(posedge hwclk);
        for (int i = 0; i < N_CH; i++) begin
            if (v && ch == i) begin
                m_mode[i] = mode;
                m_half[i] = half;
                m_k[i]    = 0;
                m_on0[i]  = (mode != 0);
                m_duty[i] = duty;
            end else begin
                m_k[i]++;
            end
        end
        m_p = (m_p + 1) % (DUTY_MAX + 1);
        @(negedge hwclk);
        cfg_valid = 1'b0;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) step(1'b0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        bit seen;
        int rv, rc, rm, rh, rd;
        reset_btn = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_half  = '0;
        cfg_duty  = '0;
        model_reset();

        repeat (5) @(negedge hwclk);
        check_reset("reset_hold");
        reset_btn = 1'b1;
        model_reset();
        idle(13, "default_blink");

        step(1'b1, 0, 2, 2, DUTY_MAX, "blink_load");
        idle(14, "blink_h2");

        step(1'b1, 1, 3, 5, DUTY_MAX, "oneshot_load");
        idle(12, "oneshot_h5");

        step(1'b1, 0, 2, 100, DUTY_MAX, "long_load");
        idle(50, "long_run");
        step(1'b1, 0, 2, 10, DUTY_MAX, "reload_h10");
        idle(25, "after_reload");

        step(1'b1, N_CH, 0, 0, 0, "bad_channel");
        idle(4, "after_bad_channel");

        // Land a transfer on ch2 exactly on its terminal edge.
        for (int t = 0; t < 8; t++) begin
            if ((m_k[2] % (m_half[2] + 1)) == m_half[2]) break;
            idle(1, "align_terminal");
        end
        step(1'b1, 2, 1, 7, 5, "load_on_terminal");
        idle(3, "after_terminal_load");

        step(1'b1, 2, 1, 0, 4, "on_duty4");
        idle(20, "on_duty4_run");
        step(1'b1, 2, 1, 0, 0, "on_duty0");
        idle(18, "on_duty0_run");

        for (int n = 0; n < 250; n++) begin
            rv = int'($urandom_range(1, 0));
            rc = int'($urandom_range(N_CH, 0));
            rm = int'($urandom_range(3, 0));
            rh = int'($urandom_range(7, 0));
            rd = int'($urandom_range(DUTY_MAX, 0));
            step(rv[0], rc, rm, rh, rd, "random");
        end

        step(1'b1, 0, 2, 4, DUTY_MAX, "pre_reset_load");
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (led[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            idle(1, "wait_led0");
        end
        n_tests++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL wait_led0 observed led0 %b expected 1 within 20 cycles", led[0]);
        end
        reset_btn = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (3) @(negedge hwclk);
        check_reset("reset_held");
        reset_btn = 1'b1;
        model_reset();
        idle(12, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
